// File: rtl/pipe_pkg.sv
// Shared pipeline constants: datapath widths and per-stage payload sizes.
// Payload pack/unpack lives in the stages that instantiate the stage register.
package pipe_pkg;

  localparam int XLEN       = 64;
  localparam int RD_W       = 5;
  localparam int LS_INFO_W  = 11;
  localparam int OPC_INFO_W = 12;
  localparam int COMMIT_W   = 161;

  localparam int IFID_DATA_W  = XLEN * 2;
  localparam int IDEX_DATA_W  = XLEN * 3 + LS_INFO_W
                              + OPC_INFO_W + COMMIT_W;
  localparam int EXMEM_DATA_W = XLEN * 3 + LS_INFO_W
                              + OPC_INFO_W + COMMIT_W;
  localparam int MEMWB_DATA_W = XLEN * 2 + COMMIT_W;

endpackage

// File: rtl/pipe_stage_reg.sv
// Stage boundary register: valid/ready handshake over a DEPTH-entry skid ring.
// rd/wen ride beside the payload so empty or flushed slots never write back.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int DATA_W         = XLEN,
  parameter int RD_W           = pipe_pkg::RD_W,
  parameter int DEPTH          = 2,
  parameter int READY_PASS     = 0,
  parameter int CLEAR_ON_FLUSH = 1,
  localparam int CW            = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [RD_W-1:0]   in_rd,
  input  logic              in_wen,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [RD_W-1:0]   out_rd,
  output logic              out_wen,
  output logic [CW-1:0]     count
);

  localparam int   PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic RPASS = 1'(READY_PASS != 0);
  localparam logic CLR   = 1'(CLEAR_ON_FLUSH != 0);

  logic [DATA_W-1:0] data_q [DEPTH];
  logic [DATA_W-1:0] data_d [DEPTH];
  logic [RD_W-1:0]   rd_q   [DEPTH];
  logic [RD_W-1:0]   rd_d   [DEPTH];
  logic              wen_q  [DEPTH];
  logic              wen_d  [DEPTH];
  logic [PW-1:0]     rp_q, rp_d;
  logic [PW-1:0]     wp_q, wp_d;
  logic [CW-1:0]     count_q, count_d;
  logic              full, empty;
  logic              push, pop;

  // Explicit compare so non-power-of-2 depths wrap correctly.
  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  always_comb begin
    full      = (count_q == CW'(DEPTH));
    empty     = (count_q == '0);
    in_ready  = rst & (~full | (RPASS & out_ready));
    out_valid = ~empty;
    push      = in_valid & in_ready & ~flush;
    pop       = out_valid & out_ready & ~flush;
  end

  always_comb begin
    data_d  = data_q;
    rd_d    = rd_q;
    wen_d   = wen_q;
    rp_d    = rp_q;
    wp_d    = wp_q;
    count_d = count_q;
    if (flush) begin
      rp_d    = '0;
      wp_d    = '0;
      count_d = '0;
      if (CLR) begin
        for (int i = 0; i < DEPTH; i++) begin
          data_d[i] = '0;
          rd_d[i]   = '0;
          wen_d[i]  = 1'b0;
        end
      end
    end else begin
      // When full with push+pop, wp == rp: the freed head is rewritten.
      if (push) begin
        data_d[wp_q] = in_data;
        rd_d[wp_q]   = in_rd;
        wen_d[wp_q]  = in_wen;
        wp_d         = nxt(wp_q);
      end
      if (pop) rp_d = nxt(rp_q);
      if (push & ~pop) count_d = count_q + CW'(1);
      else if (pop & ~push) count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rp_q    <= '0;
      wp_q    <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        data_q[i] <= '0;
        rd_q[i]   <= '0;
        wen_q[i]  <= 1'b0;
      end
    end else begin
      rp_q    <= rp_d;
      wp_q    <= wp_d;
      count_q <= count_d;
      data_q  <= data_d;
      rd_q    <= rd_d;
      wen_q   <= wen_d;
    end
  end

  always_comb begin
    out_data = data_q[rp_q];
    out_rd   = rd_q[rp_q];
    out_wen  = wen_q[rp_q] & out_valid;
    count    = count_q;
  end

endmodule
